xfft_dual_mode: RTL and testbench



---
 rtl/xfft_pkg.sv | 29 ++
 rtl/xfft_dual_mode_if.sv | 31 +++
 rtl/fft_core.sv | 57 +++++
 rtl/xfft_round_sat.sv | 65 ++++++
 rtl/xfft_dual_mode.sv | 204 ++++++++++++++++++++
 tb/tb_xfft_dual_mode.sv | 220 ++++++++++++++++++++++
 6 files changed

// File: rtl/xfft_pkg.sv
// Shared constants, types and helpers for the dual-mode FFT wrapper.
// Optional saturation counter: define XFFT_SAT_CNT_EN.
package xfft_pkg;

   localparam logic MODE_FFT  = 1'b0;
   localparam logic MODE_IFFT = 1'b1;

   localparam int ERR_GAP = 0;
   localparam int ERR_OVF = 1;
   localparam int ERR_UNF = 2;

   typedef struct packed {
      logic v;
      logic f;
      logic l;
      logic m;
   } tag_t;

   // Saturating negate of a dw-bit value held sign-extended in 32 bits.
   // Returns {saturated, result}; only the most negative input saturates.
   function automatic logic [32:0] sat_neg(input int dw,
                                           input logic signed [31:0] x);
      logic signed [31:0] mn;
      mn = -(32'sd1 <<< (dw - 1));
      if (x == mn) return {1'b1, ~mn};
      return {1'b0, -x};
   endfunction

endpackage

// File: rtl/xfft_dual_mode_if.sv
// Stream bundle between a source/sink and the dual-mode FFT wrapper.
// Optional saturation counter: define XFFT_SAT_CNT_EN.
interface xfft_dual_mode_if #(
   parameter int DW = 16
);
   logic          in_valid;
   logic          in_mode;
   logic [DW-1:0] x_real;
   logic [DW-1:0] x_img;
   logic          in_ready;
   logic [DW-1:0] y_real;
   logic [DW-1:0] y_img;
   logic          out_valid;
   logic          out_first;
   logic          out_last;
   logic          out_mode;
   logic [2:0]    err_flags;
   logic          err_clr;

   modport slave (
      input  in_valid, in_mode, x_real, x_img, err_clr,
      output in_ready, y_real, y_img, out_valid,
      output out_first, out_last, out_mode, err_flags
   );

   modport master (
      output in_valid, in_mode, x_real, x_img, err_clr,
      input  in_ready, y_real, y_img, out_valid,
      input  out_first, out_last, out_mode, err_flags
   );
endinterface

// File: rtl/fft_core.sv
// Stand-in streaming core: fixed LAT-cycle delay, emits each frame's sample 0
// on every bin (the exact transform of an impulse at index 0).
module fft_core #(
   parameter int N_LOG2 = 8,
   parameter int DW     = 16,
   parameter int LAT    = 3 << N_LOG2
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] x_real,
   input  logic [DW-1:0] x_img,
   output logic          out_valid,
   output logic [DW-1:0] y_real,
   output logic [DW-1:0] y_img
);

   localparam int AW = $clog2(LAT);

   logic [N_LOG2-1:0] cnt_d, cnt_q;
   logic [2*DW-1:0]   x0_d, x0_q, smp;
   logic [AW-1:0]     ptr_d, ptr_q;
   logic [LAT-1:0]    vl_q;
   logic [2*DW-1:0]   mem [LAT];

   // Broadcast sample 0 across the frame and advance the delay pointer
   always_comb begin
      smp   = (cnt_q == '0) ? {x_real, x_img} : x0_q;
      x0_d  = (in_valid && cnt_q == '0) ? {x_real, x_img} : x0_q;
      cnt_d = in_valid ? cnt_q + 1'b1 : cnt_q;
      ptr_d = (ptr_q == AW'(LAT - 1)) ? '0 : ptr_q + 1'b1;
   end

   // Frame counter, held sample and valid delay line
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         x0_q  <= '0;
         ptr_q <= '0;
         vl_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         x0_q  <= x0_d;
         ptr_q <= ptr_d;
         vl_q  <= {vl_q[LAT-2:0], in_valid};
      end
   end

   // Circular data delay line
   always_ff @(posedge clk) begin
      mem[ptr_q] <= smp;
   end

   assign out_valid = vl_q[LAT-1];
   assign {y_real, y_img} = mem[ptr_q];

endmodule

// File: rtl/xfft_round_sat.sv
// Two-stage round-half-up, arithmetic shift and saturate of one component.
// Optional saturation counter: define XFFT_SAT_CNT_EN.
module xfft_round_sat #(
   parameter int DW = 16,
   parameter int SW = 4
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          vld_i,
   input  logic [SW-1:0] s_i,
   input  logic [DW-1:0] d_i,
   output logic [DW-1:0] q_o,
   output logic          sat_o
);

   localparam logic signed [DW:0] MAXV = {2'b00, {(DW-1){1'b1}}};
   localparam logic signed [DW:0] MINV = {2'b11, {(DW-1){1'b0}}};

   logic signed [DW:0] acc_d, acc_q, rnd, shd;
   logic [SW-1:0]      s_d, s_q;
   logic               v_d, v_q;
   logic [DW-1:0]      q_d, q_q;

   // S1: sign-extend one bit and add the half-LSB rounding term
   always_comb begin
      rnd = '0;
      if (s_i != '0) rnd = (DW+1)'(1) << (s_i - SW'(1));
      acc_d = $signed({d_i[DW-1], d_i}) + rnd;
      s_d   = s_i;
      v_d   = vld_i;
   end

   // S2: arithmetic shift, clamp to DW bits, zero when idle
   always_comb begin
      shd   = acc_q >>> s_q;
      q_d   = shd[DW-1:0];
      sat_o = 1'b0;
      if (shd > MAXV) begin
         q_d   = MAXV[DW-1:0];
         sat_o = v_q;
      end else if (shd < MINV) begin
         q_d   = MINV[DW-1:0];
         sat_o = v_q;
      end
      if (!v_q) q_d = '0;
   end

   // Pipeline registers for both stages
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         s_q   <= '0;
         v_q   <= 1'b0;
         q_q   <= '0;
      end else begin
         acc_q <= acc_d;
         s_q   <= s_d;
         v_q   <= v_d;
         q_q   <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/xfft_dual_mode.sv
// Per-frame FFT/IFFT wrapper around fft_core with a mode FIFO.
// Optional saturation counter port sat_cnt: define XFFT_SAT_CNT_EN.
module xfft_dual_mode
   import xfft_pkg::*;
#(
   parameter int N_LOG2          = 8,
   parameter int DW              = 16,
   parameter int FFT_SHIFT       = 0,
   parameter int MODE_FIFO_DEPTH = 4
)(
   input logic              clk,
   input logic              rst,
   xfft_dual_mode_if.slave  bus
`ifdef XFFT_SAT_CNT_EN
   ,output logic [15:0]     sat_cnt
`endif
);

   localparam int SW = $clog2(N_LOG2 + 1);
   localparam int PW = (MODE_FIFO_DEPTH > 1) ? $clog2(MODE_FIFO_DEPTH) : 1;
   localparam int CW = $clog2(MODE_FIFO_DEPTH + 1);

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MODE_FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   logic [N_LOG2-1:0] in_cnt_d, in_cnt_q, out_cnt_d, out_cnt_q;
   logic              imode_d, imode_q, drop_d, drop_q, omode_d, omode_q;
   logic              mem_d [MODE_FIFO_DEPTH];
   logic              mem_q [MODE_FIFO_DEPTH];
   logic [PW-1:0]     wr_d, wr_q, rd_d, rd_q;
   logic [CW-1:0]     cnt_d, cnt_q;
   logic [2:0]        err_d, err_q;
   tag_t              tag1_d, tag1_q, tag2_q;

   logic              start, full, empty, push, pop, pop_ok;
   logic              cur_imode, cur_drop, cur_omode;
   logic              c_in_valid, c_out_valid;
   logic [DW-1:0]     c_x_img, c_y_real, c_y_img, p_img, y_re, y_im;
   logic [32:0]       pre_n, post_n;
   logic              pre_sat, post_sat, sat_re, sat_im;
   logic [SW-1:0]     s_sel;
   logic              unused_ok;

   // Input side: frame start, drop decision and pre-conjugation
   always_comb begin
      start      = bus.in_valid && in_cnt_q == '0;
      full       = cnt_q == CW'(MODE_FIFO_DEPTH);
      empty      = cnt_q == '0;
      push       = start && !full;
      cur_imode  = start ? bus.in_mode : imode_q;
      cur_drop   = start ? full : drop_q;
      c_in_valid = bus.in_valid && !cur_drop;
      pre_n      = sat_neg(DW, 32'($signed(bus.x_img)));
      c_x_img    = bus.x_img;
      pre_sat    = 1'b0;
      if (cur_imode == MODE_IFFT) begin
         c_x_img = pre_n[DW-1:0];
         pre_sat = c_in_valid && pre_n[32];
      end
      in_cnt_d = bus.in_valid ? in_cnt_q + 1'b1 : in_cnt_q;
      imode_d  = cur_imode;
      drop_d   = cur_drop;
   end

   fft_core #(
      .N_LOG2 (N_LOG2),
      .DW     (DW)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (c_in_valid),
      .x_real    (bus.x_real),
      .x_img     (c_x_img),
      .out_valid (c_out_valid),
      .y_real    (c_y_real),
      .y_img     (c_y_img)
   );

   // Output side: mode pop, post-conjugation, shift select and frame tags
   always_comb begin
      pop       = c_out_valid && out_cnt_q == '0;
      pop_ok    = pop && !empty;
      cur_omode = pop ? (empty ? MODE_FFT : mem_q[rd_q]) : omode_q;
      post_n    = sat_neg(DW, 32'($signed(c_y_img)));
      p_img     = c_y_img;
      post_sat  = 1'b0;
      if (cur_omode == MODE_IFFT) begin
         p_img    = post_n[DW-1:0];
         post_sat = c_out_valid && post_n[32];
      end
      s_sel     = (cur_omode == MODE_IFFT) ? SW'(N_LOG2) : SW'(FFT_SHIFT);
      out_cnt_d = c_out_valid ? out_cnt_q + 1'b1 : out_cnt_q;
      omode_d   = cur_omode;
      tag1_d.v  = c_out_valid;
      tag1_d.f  = c_out_valid && out_cnt_q == '0;
      tag1_d.l  = c_out_valid && (&out_cnt_q);
      tag1_d.m  = c_out_valid && cur_omode;
   end

   // Mode FIFO bookkeeping and sticky error flags
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push) begin
         mem_d[wr_q] = bus.in_mode;
         wr_d        = ptr_inc(wr_q);
      end
      if (pop_ok) rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop_ok);
      err_d = err_q;
      if (!bus.in_valid && in_cnt_q != '0) err_d[ERR_GAP] = 1'b1;
      if (start && full) err_d[ERR_OVF] = 1'b1;
      if (pop && empty) err_d[ERR_UNF] = 1'b1;
      if (bus.err_clr) err_d = '0;
   end

   xfft_round_sat #(.DW(DW), .SW(SW)) u_rs_re (
      .clk   (clk),
      .rst   (rst),
      .vld_i (c_out_valid),
      .s_i   (s_sel),
      .d_i   (c_y_real),
      .q_o   (y_re),
      .sat_o (sat_re)
   );

   xfft_round_sat #(.DW(DW), .SW(SW)) u_rs_im (
      .clk   (clk),
      .rst   (rst),
      .vld_i (c_out_valid),
      .s_i   (s_sel),
      .d_i   (p_img),
      .q_o   (y_im),
      .sat_o (sat_im)
   );

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         imode_q   <= MODE_FFT;
         drop_q    <= 1'b0;
         omode_q   <= MODE_FFT;
         mem_q     <= '{default: 1'b0};
         wr_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
         err_q     <= '0;
         tag1_q    <= '0;
         tag2_q    <= '0;
      end else begin
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         imode_q   <= imode_d;
         drop_q    <= drop_d;
         omode_q   <= omode_d;
         mem_q     <= mem_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         tag1_q    <= tag1_d;
         tag2_q    <= tag1_q;
      end
   end

   assign bus.in_ready  = !full || in_cnt_q != '0;
   assign bus.y_real    = y_re;
   assign bus.y_img     = y_im;
   assign bus.out_valid = tag2_q.v;
   assign bus.out_first = tag2_q.f;
   assign bus.out_last  = tag2_q.l;
   assign bus.out_mode  = tag2_q.m;
   assign bus.err_flags = err_q;

`ifdef XFFT_SAT_CNT_EN
   logic [15:0] sat_cnt_d, sat_cnt_q;
   logic [16:0] sat_sum;

   // Saturating count of every clamped component
   always_comb begin
      sat_sum = {1'b0, sat_cnt_q} + 17'(pre_sat) + 17'(post_sat)
              + 17'(sat_re) + 17'(sat_im);
      sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      if (bus.err_clr) sat_cnt_d = '0;
   end

   // Saturation counter register
   always_ff @(posedge clk) begin
      if (rst) sat_cnt_q <= '0;
      else     sat_cnt_q <= sat_cnt_d;
   end

   assign sat_cnt   = sat_cnt_q;
   assign unused_ok = ^{pre_n[31:DW], post_n[31:DW]};
`else
   assign unused_ok = ^{pre_n[31:DW], post_n[31:DW],
                        pre_sat, post_sat, sat_re, sat_im};
`endif

endmodule

// File: tb/tb_xfft_dual_mode.sv
// Scoreboard bench for xfft_dual_mode (DEPTH=2, 3-frame core latency).
// Optional saturation counter: define XFFT_SAT_CNT_EN.
module tb_xfft_dual_mode;
   import xfft_pkg::*;

   localparam int N   = 256;
   localparam int DW  = 16;
   localparam int LAT = 3 * N + 2;

   typedef struct {
      logic [DW-1:0] re;
      logic [DW-1:0] im;
      logic          f;
      logic          l;
      logic          m;
      int            at;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   xfft_dual_mode_if #(.DW(DW)) bus ();

`ifdef XFFT_SAT_CNT_EN
   logic [15:0] sat_cnt;
`endif

   xfft_dual_mode #(
      .N_LOG2          (8),
      .DW              (DW),
      .FFT_SHIFT       (0),
      .MODE_FIFO_DEPTH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef XFFT_SAT_CNT_EN
      ,.sat_cnt (sat_cnt)
`endif
   );

   always @(posedge clk) cyc++;

   // monitor: pop the scoreboard on every output sample
   always @(negedge clk) begin
      exp_t e;
      tests++;
      if (bus.out_valid) begin
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_out: re=%0d im=%0d cyc=%0d, none expected",
                     $signed(bus.y_real), $signed(bus.y_img), cyc);
         end else begin
            e = sb.pop_front();
            if (bus.y_real !== e.re || bus.y_img !== e.im ||
                bus.out_first !== e.f || bus.out_last !== e.l ||
                bus.out_mode !== e.m || cyc != e.at) begin
               fails++;
               $display("FAIL sample: got re=%0d im=%0d f=%0b l=%0b m=%0b cyc=%0d want re=%0d im=%0d f=%0b l=%0b m=%0b cyc=%0d",
                        $signed(bus.y_real), $signed(bus.y_img), bus.out_first,
                        bus.out_last, bus.out_mode, cyc, $signed(e.re),
                        $signed(e.im), e.f, e.l, e.m, e.at);
            end
         end
      end else if (bus.y_real !== '0 || bus.y_img !== '0 ||
                   bus.out_first !== 1'b0 || bus.out_last !== 1'b0 ||
                   bus.out_mode !== 1'b0) begin
         fails++;
         $display("FAIL idle_out: re=%0h im=%0h f=%0b l=%0b m=%0b want all 0",
                  bus.y_real, bus.y_img, bus.out_first, bus.out_last, bus.out_mode);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // drive one frame; x[0] = r0 + j*i0, rest 0; expected bin value er + j*ei
   task automatic send(input logic mode, input logic [DW-1:0] r0,
                       input logic [DW-1:0] i0, input logic [DW-1:0] er,
                       input logic [DW-1:0] ei, input bit accept,
                       input int gap_at, input int gap_len, input int rst_at);
      int w;
      w = 0;
      if (accept) begin
         while (!bus.in_ready && w < 3000) begin
            tick();
            w++;
         end
         chk("ready_wait", {31'd0, bus.in_ready}, 32'd1);
      end
      for (int i = 0; i < N; i++) begin
         if (i == gap_at) begin
            bus.in_valid = 1'b0;
            repeat (gap_len) tick();
         end
         bus.in_valid = 1'b1;
         bus.in_mode  = (i == 0) ? mode : ~mode;
         bus.x_real   = (i == 0) ? r0 : '0;
         bus.x_img    = (i == 0) ? i0 : '0;
         if (i == rst_at) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            bus.in_valid = 1'b0;
            bus.x_real   = '0;
            bus.x_img    = '0;
            sb.delete();
            return;
         end
         if (accept)
            sb.push_back('{re: er, im: ei, f: (i == 0), l: (i == N - 1),
                           m: mode, at: cyc + LAT});
         tick();
      end
      bus.in_valid = 1'b0;
      bus.x_real   = '0;
      bus.x_img    = '0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 4000) begin
         tick();
         w++;
      end
      chk("drain_left", sb.size(), 0);
      repeat (4) tick();
   endtask

   task automatic clr();
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      fails++;
      $display("FAIL watchdog: time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_mode  = 1'b0;
      bus.x_real   = '0;
      bus.x_img    = '0;
      bus.err_clr  = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_y", {bus.y_real, bus.y_img}, 32'd0);
      chk("rst_err", {29'd0, bus.err_flags}, 32'd0);
      chk("rst_tags", {29'd0, bus.out_first, bus.out_last, bus.out_mode}, 32'd0);

      // IFFT impulse, FFT impulse back-to-back, third frame overflows
      send(MODE_IFFT, 16'd256, 16'd0, 16'd1, 16'd0, 1, -1, 0, -1);
      send(MODE_FFT, 16'd100, 16'd0, 16'd100, 16'd0, 1, -1, 0, -1);
      chk("full_ready", {31'd0, bus.in_ready}, 32'd0);
      send(MODE_IFFT, 16'd256, 16'd0, 16'd1, 16'd0, 0, -1, 0, -1);
      chk("ovf_flag", {29'd0, bus.err_flags}, 32'b010);
      drain();
      clr();
      chk("clr_ovf", {29'd0, bus.err_flags}, 32'd0);

      // rounding and saturation through the post stage
      send(MODE_IFFT, 16'hFF80, 16'hFF7F, 16'd0, 16'hFFFF, 1, -1, 0, -1);
      send(MODE_IFFT, 16'd127, 16'd128, 16'd0, 16'd1, 1, -1, 0, -1);
      send(MODE_IFFT, 16'h7FFF, 16'h8000, 16'd128, 16'hFF80, 1, -1, 0, -1);
      send(MODE_FFT, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1, -1, 0, -1);
      drain();
      chk("no_err_round", {29'd0, bus.err_flags}, 32'd0);
`ifdef XFFT_SAT_CNT_EN
      chk("sat_cnt", {16'd0, sat_cnt}, 32'd1);
`endif

      // input gap of 5 cycles at sample 100
      send(MODE_FFT, 16'd7, 16'hFFFD, 16'd7, 16'hFFFD, 1, 100, 5, -1);
      chk("gap_flag", {29'd0, bus.err_flags}, 32'b001);
      drain();
      clr();
      chk("clr_gap", {29'd0, bus.err_flags}, 32'd0);

      // reset pulse mid-frame, then a clean frame
      send(MODE_IFFT, 16'd512, 16'd0, 16'd2, 16'd0, 1, -1, 0, 50);
      chk("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mrst_y", {bus.y_real, bus.y_img}, 32'd0);
      chk("mrst_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("mrst_err", {29'd0, bus.err_flags}, 32'd0);
      send(MODE_FFT, 16'hFFFB, 16'd9, 16'hFFFB, 16'd9, 1, -1, 0, -1);
      drain();
      chk("final_err", {29'd0, bus.err_flags}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
